// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
package inst_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam logic [1:0]  SIZE_WORD        = 2'd2;
  localparam int          INST_W           = 32;

  // Sequential fetch advances one 32-bit instruction word.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Core-side instruction stream plus the sram-like bridge port.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [INST_W-1:0] out_inst;
  logic              inst_sram_req;
  logic              inst_sram_wr;
  logic [1:0]        inst_sram_size;
  logic [3:0]        inst_sram_wstrb;
  logic [31:0]       inst_sram_addr;
  logic [31:0]       inst_sram_wdata;
  logic              inst_sram_addr_ok;
  logic              inst_sram_data_ok;
  logic [31:0]       inst_sram_rdata;

  // Fetch queue side
  modport slave (
    input  redirect_valid, redirect_pc, out_ready,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output out_valid, out_pc, out_inst,
           inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata
  );

  // Core + bridge side
  modport master (
    output redirect_valid, redirect_pc, out_ready,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  out_valid, out_pc, out_inst,
           inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// In-order queue of fetched PCs; entries are allocated at request accept
// and filled by responses, which return in request order.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_alloc,
  input  logic [31:0]       i_alloc_pc,
  input  logic              i_fill,
  input  logic [INST_W-1:0] i_fill_inst,
  input  logic              i_pop,
  output logic [CW-1:0]     o_count,
  output logic [CW-1:0]     o_unfilled,
  output logic              o_head_valid,
  output logic [31:0]       o_head_pc,
  output logic [INST_W-1:0] o_head_inst
);

  logic [CW-1:0]     r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [DEPTH-1:0]  r_filled;
  logic [31:0]       r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [AW-1:0]     w_alloc_idx, w_fill_idx, w_head_idx;

  assign w_alloc_idx  = r_alloc_ptr[AW-1:0];
  assign w_fill_idx   = r_fill_ptr[AW-1:0];
  assign w_head_idx   = r_head_ptr[AW-1:0];
  assign o_count      = r_alloc_ptr - r_head_ptr;
  assign o_unfilled   = r_alloc_ptr - r_fill_ptr;
  // Filled bits of popped slots go stale, so an empty queue must mask them.
  assign o_head_valid = (o_count != '0) && r_filled[w_head_idx];
  assign o_head_pc    = r_pc[w_head_idx];
  assign o_head_inst  = r_inst[w_head_idx];

  // Pointer update; a flush empties the queue and overrides everything else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
    end else begin
      if (i_alloc) r_alloc_ptr <= r_alloc_ptr + CW'(1);
      if (i_fill)  r_fill_ptr  <= r_fill_ptr + CW'(1);
      if (i_pop)   r_head_ptr  <= r_head_ptr + CW'(1);
    end
  end

  // Entry storage; alloc and fill never hit the same slot in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (!i_flush) begin
      if (i_alloc) begin
        r_pc[w_alloc_idx]     <= i_alloc_pc;
        r_filled[w_alloc_idx] <= 1'b0;
      end
      if (i_fill) begin
        r_inst[w_fill_idx]   <= i_fill_inst;
        r_filled[w_fill_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues sequential sram-like requests, caps in-flight
// work at DEPTH, and drops responses of requests cancelled by a redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  inst_fetch_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic          r_req;
  logic [31:0]   r_addr;
  logic          r_redirect_pending;
  logic [31:0]   r_redirect_pc;
  logic [CW-1:0] r_discard;

  logic          w_acc, w_hold, w_drop, w_fill, w_alloc, w_pop, w_room;
  logic          w_head_valid;
  logic [CW-1:0] w_count, w_unfilled, w_count_next, w_discard_next;
  logic          w_req_next, w_pending_next;
  logic [31:0]   w_addr_next, w_redirect_pc_next;

  assign w_acc   = r_req & bus.inst_sram_addr_ok;
  assign w_hold  = r_req & ~bus.inst_sram_addr_ok;
  assign w_drop  = bus.inst_sram_data_ok & (r_discard != '0);
  assign w_fill  = bus.inst_sram_data_ok & (r_discard == '0) & ~bus.redirect_valid;
  // A request accepted after a redirect (pending or same-cycle) is never queued.
  assign w_alloc = w_acc & ~r_redirect_pending & ~bus.redirect_valid;
  assign w_pop   = w_head_valid & bus.out_ready & ~bus.redirect_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .i_flush      (bus.redirect_valid),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_addr),
    .i_fill       (w_fill),
    .i_fill_inst  (bus.inst_sram_rdata),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled),
    .o_head_valid (w_head_valid),
    .o_head_pc    (bus.out_pc),
    .o_head_inst  (bus.out_inst)
  );

  // Occupancy after this cycle's events, used to gate the next request.
  always_comb begin
    w_discard_next = r_discard;
    if (bus.redirect_valid)
      // Every outstanding request is now stale; a same-cycle response retires the oldest.
      w_discard_next = r_discard + w_unfilled + CW'(w_acc) - CW'(bus.inst_sram_data_ok);
    else
      w_discard_next = r_discard + CW'(w_acc & r_redirect_pending) - CW'(w_drop);
    w_count_next = bus.redirect_valid ? '0 : (w_count + CW'(w_alloc) - CW'(w_pop));
    w_room       = (SW'(w_count_next) + SW'(w_discard_next)) < SW'(DEPTH);
  end

  // Next request: a held request is frozen, otherwise reissue when room allows.
  always_comb begin
    w_req_next         = r_req;
    w_addr_next        = r_addr;
    w_pending_next     = r_redirect_pending;
    w_redirect_pc_next = r_redirect_pc;
    if (w_hold) begin
      w_req_next = 1'b1;
      if (bus.redirect_valid) begin
        w_pending_next     = 1'b1;
        w_redirect_pc_next = bus.redirect_pc;
      end
    end else begin
      w_req_next     = w_room;
      w_pending_next = 1'b0;
      if (bus.redirect_valid)
        w_addr_next = bus.redirect_pc;
      else if (r_redirect_pending)
        w_addr_next = r_redirect_pc;
      else if (w_acc)
        w_addr_next = next_seq_pc(r_addr);
    end
  end

  // Request, redirect and discard registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req              <= 1'b0;
      r_addr             <= RESET_PC;
      r_redirect_pending <= 1'b0;
      r_redirect_pc      <= '0;
      r_discard          <= '0;
    end else begin
      r_req              <= w_req_next;
      r_addr             <= w_addr_next;
      r_redirect_pending <= w_pending_next;
      r_redirect_pc      <= w_redirect_pc_next;
      r_discard          <= w_discard_next;
    end
  end

  assign bus.out_valid       = w_head_valid;
  assign bus.inst_sram_req   = r_req;
  assign bus.inst_sram_addr  = r_addr;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = SIZE_WORD;
  assign bus.inst_sram_wstrb = '0;
  assign bus.inst_sram_wdata = '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench: a simple in-order bridge model answers accepted requests,
// and each step checks hand-derived request/queue state.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc00000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  bit resp_en = 1'b0;
  logic [31:0] bq[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    bus.inst_sram_data_ok = resp_en && (bq.size() > 0);
    bus.inst_sram_rdata   = bus.inst_sram_data_ok ? inst_of(bq[0]) : 32'h0;
  endtask

  // One clock: record handshakes seen before the edge, update the bridge after it.
  task automatic tick();
    logic acc, rsp;
    logic [31:0] a;
    acc = bus.inst_sram_req & bus.inst_sram_addr_ok;
    rsp = bus.inst_sram_data_ok;
    a   = bus.inst_sram_addr;
    @(posedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    if (rsp === 1'b1 && bq.size() > 0) void'(bq.pop_front());
    if (acc === 1'b1) begin
      bq.push_back(a);
      acc_cnt++;
    end
    drive_rsp();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = 32'h0;
    bus.out_ready         = 1'b0;
    bus.inst_sram_addr_ok = 1'b0;
    resp_en = 1'b0;
    bq.delete();
    drive_rsp();
    @(negedge clk);
    @(negedge clk);
    acc_cnt = 0;
  endtask

  initial begin
    // Reset values and constant outputs
    do_reset();
    chk("rst_req",   bus.inst_sram_req, 32'd0);
    chk("rst_addr",  bus.inst_sram_addr, 32'hbfc00000);
    chk("rst_oval",  bus.out_valid, 32'd0);
    chk("rst_opc",   bus.out_pc, 32'd0);
    chk("rst_oinst", bus.out_inst, 32'd0);
    chk("c_size",    bus.inst_sram_size, 32'd2);
    chk("c_wr",      bus.inst_sram_wr, 32'd0);
    chk("c_wstrb",   bus.inst_sram_wstrb, 32'd0);
    chk("c_wdata",   bus.inst_sram_wdata, 32'd0);

    // Streaming fetch with single-cycle bridge
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b1; bus.out_ready = 1'b1; resetn = 1'b1;
    chk("s1_c0_req", bus.inst_sram_req, 32'd0);
    tick();
    chk("s1_c1_req",  bus.inst_sram_req, 32'd1);
    chk("s1_c1_addr", bus.inst_sram_addr, 32'hbfc00000);
    tick();
    chk("s1_c2_addr", bus.inst_sram_addr, 32'hbfc00004);
    chk("s1_c2_oval", bus.out_valid, 32'd0);
    tick();
    chk("s1_c3_oval", bus.out_valid, 32'd1);
    chk("s1_c3_pc",   bus.out_pc, 32'hbfc00000);
    chk("s1_c3_inst", bus.out_inst, inst_of(32'hbfc00000));
    chk("s1_c3_addr", bus.inst_sram_addr, 32'hbfc00008);
    tick();
    chk("s1_c4_pc",   bus.out_pc, 32'hbfc00004);
    tick();
    chk("s1_c5_pc",   bus.out_pc, 32'hbfc00008);
    chk("s1_c5_inst", bus.out_inst, inst_of(32'hbfc00008));

    // Back-pressure: cap at 4, one pop frees one slot
    do_reset();
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b1; bus.out_ready = 1'b0; resetn = 1'b1;
    repeat (10) tick();
    chk("s2_acc4",  acc_cnt, 32'd4);
    chk("s2_full_req", bus.inst_sram_req, 32'd0);
    chk("s2_full_addr", bus.inst_sram_addr, 32'hbfc00010);
    chk("s2_head_pc", bus.out_pc, 32'hbfc00000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("s2_pop_req",  bus.inst_sram_req, 32'd1);
    chk("s2_pop_addr", bus.inst_sram_addr, 32'hbfc00010);
    chk("s2_pop_pc",   bus.out_pc, 32'hbfc00004);
    repeat (4) tick();
    chk("s2_acc5",  acc_cnt, 32'd5);
    chk("s2_req_off", bus.inst_sram_req, 32'd0);

    // Redirect with 2 queued unfilled plus one accepted the same cycle
    do_reset();
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b0; bus.out_ready = 1'b0; resetn = 1'b1;
    repeat (3) tick();
    chk("s3_pre_addr", bus.inst_sram_addr, 32'hbfc00008);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80001000;
    tick();
    chk("s3_rd_addr", bus.inst_sram_addr, 32'h80001000);
    chk("s3_rd_req",  bus.inst_sram_req, 32'd1);
    tick();
    chk("s3_cap_req", bus.inst_sram_req, 32'd0);
    resp_en = 1'b1; drive_rsp();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_drop_oval", bus.out_valid, 32'd0);
    end
    tick();
    chk("s3_oval", bus.out_valid, 32'd1);
    chk("s3_pc",   bus.out_pc, 32'h80001000);
    chk("s3_inst", bus.out_inst, inst_of(32'h80001000));

    // Redirect while a request is held without addr_ok
    do_reset();
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b1; bus.out_ready = 1'b1; resetn = 1'b1;
    repeat (3) tick();
    chk("s4_pre_addr", bus.inst_sram_addr, 32'hbfc00008);
    chk("s4_pre_pc",   bus.out_pc, 32'hbfc00000);
    bus.inst_sram_addr_ok = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80001000;
    tick();
    chk("s4_hold_addr", bus.inst_sram_addr, 32'hbfc00008);
    chk("s4_hold_req",  bus.inst_sram_req, 32'd1);
    chk("s4_flush_oval", bus.out_valid, 32'd0);
    tick();
    chk("s4_hold_addr2", bus.inst_sram_addr, 32'hbfc00008);
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    chk("s4_new_addr", bus.inst_sram_addr, 32'h80001000);
    chk("s4_new_oval", bus.out_valid, 32'd0);
    tick();
    chk("s4_drop_oval", bus.out_valid, 32'd0);
    tick();
    chk("s4_oval", bus.out_valid, 32'd1);
    chk("s4_pc",   bus.out_pc, 32'h80001000);

    // Redirect coinciding with data_ok and addr_ok, 2 unfilled
    do_reset();
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b0; bus.out_ready = 1'b1; resetn = 1'b1;
    repeat (3) tick();
    resp_en = 1'b1; drive_rsp();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80002000;
    tick();
    chk("s5_addr", bus.inst_sram_addr, 32'h80002000);
    chk("s5_oval_a", bus.out_valid, 32'd0);
    tick();
    chk("s5_oval_b", bus.out_valid, 32'd0);
    tick();
    chk("s5_oval_c", bus.out_valid, 32'd0);
    tick();
    chk("s5_oval", bus.out_valid, 32'd1);
    chk("s5_pc",   bus.out_pc, 32'h80002000);

    // Asynchronous reset mid-transaction
    do_reset();
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b1; bus.out_ready = 1'b0; resetn = 1'b1;
    repeat (3) tick();
    chk("s6_pre_oval", bus.out_valid, 32'd1);
    chk("s6_pre_req",  bus.inst_sram_req, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("s6_async_req",  bus.inst_sram_req, 32'd0);
    chk("s6_async_oval", bus.out_valid, 32'd0);
    chk("s6_async_addr", bus.inst_sram_addr, 32'hbfc00000);
    bus.inst_sram_addr_ok = 1'b0; resp_en = 1'b0; bq.delete(); drive_rsp();
    @(negedge clk);
    @(negedge clk);
    bus.inst_sram_addr_ok = 1'b1; resp_en = 1'b1; bus.out_ready = 1'b1; resetn = 1'b1;
    tick();
    chk("s6_re_req",  bus.inst_sram_req, 32'd1);
    chk("s6_re_addr", bus.inst_sram_addr, 32'hbfc00000);
    tick();
    tick();
    chk("s6_re_oval", bus.out_valid, 32'd1);
    chk("s6_re_pc",   bus.out_pc, 32'hbfc00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
